cordic_rot_scheduler: RTL and testbench

// - Shares one fixed-latency doubly-pipelined CORDIC rotation datapath among NREQ requesters.
// - Each job is one Givens-style rotation: vector (a,b) sets the angle, and (p,q) is rotated by that angle.
// - Round-robin arbitration feeds at most one job per cycle into the pipeline.
// - A LATENCY-deep tag shift register routes each result back to its requester, and per-requester credit counters bound outstanding jobs.

---
 rtl/cordic_sched_pkg.sv | 27 ++
 rtl/cordic_rot_scheduler_rr_arbiter.sv | 52 +++++
 rtl/cordic_rot_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_cordic_rot_scheduler.sv | 476 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_sched_pkg.sv
// Shared definitions for the CORDIC rotation scheduler: default geometry,
// requester-id width helper and the tag carried alongside each job.
package cordic_sched_pkg;

  localparam int DEF_NREQ    = 4;
  localparam int DEF_W       = 32;
  localparam int DEF_ANG_W   = 16;
  localparam int DEF_LATENCY = 14;
  localparam int DEF_MAX_OUT = 4;

  // Largest supported requester count and the id width that covers it.
  // The tag is sized for the maximum so one type serves every NREQ.
  localparam int MAX_NREQ = 8;
  localparam int TAG_ID_W = 3;

  // Bits needed to name one of n requesters (never less than one bit).
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // One entry of the tag shift register: marks a live job and its owner.
  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/cordic_rot_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first eligible requester at or after the
// rotating pointer; the pointer moves past the winner only when a grant occurs.
module rr_arbiter
  import cordic_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int ID_W = id_width(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] elig,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] grant_id,
  output logic            grant_any
);

  logic [ID_W-1:0] ptr_reg;
  // One extra bit so ptr + offset cannot overflow before the wrap.
  logic [ID_W:0]   idx;

  // Search from ptr upward; scanning offsets high-to-low leaves the nearest
  // eligible requester as the final (winning) assignment.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    idx       = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr_reg} + (ID_W + 1)'(k);
      if (idx >= (ID_W + 1)'(NREQ)) begin
        idx = idx - (ID_W + 1)'(NREQ);
      end
      if (elig[idx[ID_W-1:0]]) begin
        grant_id  = idx[ID_W-1:0];
        grant_any = 1'b1;
      end
    end
    if (grant_any) begin
      grant[grant_id] = 1'b1;
    end
  end

  // Advance the pointer to the requester after the winner (mod NREQ).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg <= '0;
    end else if (grant_any) begin
      ptr_reg <= (grant_id == ID_W'(NREQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/cordic_rot_scheduler.sv
// Shares one fixed-latency CORDIC rotation datapath among NREQ requesters.
// Jobs are granted round-robin (one per cycle), registered out to the
// datapath, tracked by a LATENCY-deep tag pipe and returned with the owner id.
// Per-requester credits cap the number of outstanding jobs at MAX_OUT.
module cordic_rot_scheduler
  import cordic_sched_pkg::*;
#(
  parameter int  NREQ    = DEF_NREQ,
  parameter int  W       = DEF_W,
  parameter int  ANG_W   = DEF_ANG_W,
  parameter int  LATENCY = DEF_LATENCY,
  parameter int  MAX_OUT = DEF_MAX_OUT,
  localparam int ID_W    = id_width(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sched_en,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*W-1:0] req_p,
  input  logic [NREQ*W-1:0] req_q,
  output logic              pipe_valid_o,
  output logic [W-1:0]      pipe_a,
  output logic [W-1:0]      pipe_b,
  output logic [W-1:0]      pipe_p,
  output logic [W-1:0]      pipe_q,
  input  logic [W-1:0]      pipe_pf_i,
  input  logic [W-1:0]      pipe_qf_i,
  input  logic [ANG_W-1:0]  pipe_angle_i,
  output logic              rsp_valid,
  output logic [ID_W-1:0]   rsp_id,
  output logic [W-1:0]      rsp_pf,
  output logic [W-1:0]      rsp_qf,
  output logic [ANG_W-1:0]  rsp_angle,
  output logic              busy
);

  localparam int CRED_W = $clog2(MAX_OUT + 1);

  logic [NREQ-1:0]    credit_ok;
  logic [NREQ-1:0]    elig;
  logic [NREQ-1:0]    grant;
  logic [ID_W-1:0]    grant_id;
  logic               grant_any;

  logic [ID_W-1:0]    pipe_id_reg;
  tag_t               tag_in;
  tag_t               tag_out;
  tag_t               tag_reg [LATENCY];
  logic [LATENCY-1:0] tag_valid;
  logic               unused_tag_id_hi;

  // ------------------------------------------------------------------
  // Arbitration. Reset also masks eligibility so req_ready reads zero
  // while rst is held, even though it is otherwise combinational.
  // ------------------------------------------------------------------
  assign elig      = req_valid & credit_ok & {NREQ{sched_en & ~rst}};
  assign req_ready = grant;

  rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .elig      (elig),
    .grant     (grant),
    .grant_id  (grant_id),
    .grant_any (grant_any)
  );

  // ------------------------------------------------------------------
  // Issue register: the granted operands reach the datapath the cycle
  // after the handshake; operands hold their last value when idle.
  // ------------------------------------------------------------------
  // Capture the winner's operand slice and id on every grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_valid_o <= 1'b0;
      pipe_a       <= '0;
      pipe_b       <= '0;
      pipe_p       <= '0;
      pipe_q       <= '0;
      pipe_id_reg  <= '0;
    end else begin
      pipe_valid_o <= grant_any;
      if (grant_any) begin
        pipe_a      <= req_a[int'(grant_id) * W +: W];
        pipe_b      <= req_b[int'(grant_id) * W +: W];
        pipe_p      <= req_p[int'(grant_id) * W +: W];
        pipe_q      <= req_q[int'(grant_id) * W +: W];
        pipe_id_reg <= grant_id;
      end
    end
  end

  // ------------------------------------------------------------------
  // Tag pipe: follows the issue register, so its last stage lines up
  // with the datapath result that arrives LATENCY cycles after issue.
  // ------------------------------------------------------------------
  assign tag_in.valid = pipe_valid_o;
  assign tag_in.id    = TAG_ID_W'(pipe_id_reg);
  assign tag_out      = tag_reg[LATENCY-1];

  // Upper id bits of the shared tag type are zero for small NREQ.
  assign unused_tag_id_hi = ^tag_out.id;

  // Shift tags one stage per cycle; reset drops every in-flight job.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < LATENCY; s++) begin
        tag_reg[s] <= '0;
      end
    end else begin
      tag_reg[0] <= tag_in;
      for (int s = 1; s < LATENCY; s++) begin
        tag_reg[s] <= tag_reg[s-1];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LATENCY; gi++) begin : g_tag_valid
      assign tag_valid[gi] = tag_reg[gi].valid;
    end
  endgenerate

  // ------------------------------------------------------------------
  // Response register: results are only taken when a live tag is at the
  // end of the pipe, so stale datapath output after a reset is ignored.
  // ------------------------------------------------------------------
  // Register the datapath result together with its owner id.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_pf    <= '0;
      rsp_qf    <= '0;
      rsp_angle <= '0;
    end else begin
      rsp_valid <= tag_out.valid;
      if (tag_out.valid) begin
        rsp_id    <= tag_out.id[ID_W-1:0];
        rsp_pf    <= pipe_pf_i;
        rsp_qf    <= pipe_qf_i;
        rsp_angle <= pipe_angle_i;
      end
    end
  end

  // ------------------------------------------------------------------
  // Credits: jobs granted but not yet answered, one counter per requester.
  // The decrement uses the registered response, so a freed slot becomes
  // grantable the cycle after rsp_valid.
  // ------------------------------------------------------------------
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_credit
      logic [CRED_W-1:0] credit_reg;
      logic              credit_inc;
      logic              credit_dec;

      assign credit_inc    = grant[gi];
      assign credit_dec    = rsp_valid && (rsp_id == ID_W'(gi));
      assign credit_ok[gi] = (credit_reg < CRED_W'(MAX_OUT));

      // Count up on grant, down on response; both together cancel out.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          credit_reg <= '0;
        end else begin
          assert (!(credit_inc && !credit_dec && credit_reg >= CRED_W'(MAX_OUT)));
          assert (!(credit_dec && !credit_inc && credit_reg == '0));
          if (credit_inc && !credit_dec) begin
            credit_reg <= credit_reg + 1'b1;
          end else if (credit_dec && !credit_inc) begin
            credit_reg <= credit_reg - 1'b1;
          end
        end
      end
    end
  endgenerate

  assign busy = (|tag_valid) | rsp_valid | pipe_valid_o;

endmodule

// File: tb/tb_cordic_rot_scheduler.sv
// Self-checking bench for cordic_rot_scheduler. The datapath is modelled as
// a LATENCY-cycle delay of p and q, with angle = a (and every job uses a = id).
// Accepted handshakes push expected responses to a scoreboard; the monitor
// pops and compares when rsp_valid appears, including the arrival cycle.
module tb_cordic_rot_scheduler;

  localparam int NREQ    = 4;
  localparam int W       = 32;
  localparam int ANG_W   = 16;
  localparam int LAT     = 14;
  localparam int MAX_OUT = 4;
  localparam int ID_W    = 2;
  localparam int RSP_DLY = LAT + 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              sched_en = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a, req_b, req_p, req_q;
  logic              pipe_valid_o;
  logic [W-1:0]      pipe_a, pipe_b, pipe_p, pipe_q;
  logic [W-1:0]      pipe_pf_i, pipe_qf_i;
  logic [ANG_W-1:0]  pipe_angle_i;
  logic              rsp_valid;
  logic [ID_W-1:0]   rsp_id;
  logic [W-1:0]      rsp_pf, rsp_qf;
  logic [ANG_W-1:0]  rsp_angle;
  logic              busy;

  logic [W-1:0]      drv_a [NREQ];
  logic [W-1:0]      drv_b [NREQ];
  logic [W-1:0]      drv_p [NREQ];
  logic [W-1:0]      drv_q [NREQ];

  logic [W-1:0]      dl_p   [LAT];
  logic [W-1:0]      dl_q   [LAT];
  logic [ANG_W-1:0]  dl_ang [LAT];

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int               id;
    logic [W-1:0]     pf;
    logic [W-1:0]     qf;
    logic [ANG_W-1:0] ang;
    int               due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  exp_t push_e;

  cordic_rot_scheduler #(
    .NREQ    (NREQ),
    .W       (W),
    .ANG_W   (ANG_W),
    .LATENCY (LAT),
    .MAX_OUT (MAX_OUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sched_en     (sched_en),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_p        (req_p),
    .req_q        (req_q),
    .pipe_valid_o (pipe_valid_o),
    .pipe_a       (pipe_a),
    .pipe_b       (pipe_b),
    .pipe_p       (pipe_p),
    .pipe_q       (pipe_q),
    .pipe_pf_i    (pipe_pf_i),
    .pipe_qf_i    (pipe_qf_i),
    .pipe_angle_i (pipe_angle_i),
    .rsp_valid    (rsp_valid),
    .rsp_id       (rsp_id),
    .rsp_pf       (rsp_pf),
    .rsp_qf       (rsp_qf),
    .rsp_angle    (rsp_angle),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Datapath model: fixed delay, not reset (stale results must be ignored).
  always @(posedge clk) begin
    dl_p[0]   <= pipe_p;
    dl_q[0]   <= pipe_q;
    dl_ang[0] <= pipe_a[ANG_W-1:0];
    for (int k = 1; k < LAT; k++) begin
      dl_p[k]   <= dl_p[k-1];
      dl_q[k]   <= dl_q[k-1];
      dl_ang[k] <= dl_ang[k-1];
    end
  end

  assign pipe_pf_i    = dl_p[LAT-1];
  assign pipe_qf_i    = dl_q[LAT-1];
  assign pipe_angle_i = dl_ang[LAT-1];

  always_comb begin
    req_a = '0;
    req_b = '0;
    req_p = '0;
    req_q = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = drv_a[i];
      req_b[i*W +: W] = drv_b[i];
      req_p[i*W +: W] = drv_p[i];
      req_q[i*W +: W] = drv_q[i];
    end
  end

  // Scoreboard monitor: compare responses, flag late ones, record grants.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (rsp_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: got rsp_id=%0d at cycle %0d, required no response", rsp_id, cyc);
        end else begin
          mon_e = sb.pop_front();
          if (rsp_id !== ID_W'(mon_e.id) || rsp_pf !== mon_e.pf || rsp_qf !== mon_e.qf ||
              rsp_angle !== mon_e.ang || cyc != mon_e.due) begin
            errors++;
            $display("FAIL rsp_match: got id=%0d pf=%h qf=%h ang=%h cycle=%0d, required id=%0d pf=%h qf=%h ang=%h cycle=%0d",
                     rsp_id, rsp_pf, rsp_qf, rsp_angle, cyc,
                     mon_e.id, mon_e.pf, mon_e.qf, mon_e.ang, mon_e.due);
          end
        end
      end
      if (sb.size() > 0 && sb[0].due < cyc) begin
        checks++;
        errors++;
        $display("FAIL rsp_missing: got nothing by cycle %0d, required id=%0d at cycle %0d", cyc, sb[0].id, sb[0].due);
        mon_e = sb.pop_front();
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          push_e.id  = i;
          push_e.pf  = drv_p[i];
          push_e.qf  = drv_q[i];
          push_e.ang = ANG_W'(i);
          push_e.due = cyc + RSP_DLY;
          sb.push_back(push_e);
        end
      end
    end
  end

  task automatic set_ops(input int c);
    for (int i = 0; i < NREQ; i++) begin
      drv_a[i] = W'(i);
      drv_b[i] = 32'h0000_4000 + W'(i);
      drv_p[i] = (W'(i) << 24) | W'(c + 1);
      drv_q[i] = W'(c * 3 + i) ^ 32'h5A5A_0000;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at cycle 0: reset has just been released.
  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    sched_en  = 1'b1;
    set_ops(0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [W-1:0] exp_p;
    rst       = 1'b1;
    sched_en  = 1'b1;
    req_valid = '1;
    set_ops(0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== '0 || pipe_valid_o !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got ready=%b pv=%b rv=%b busy=%b, required all 0", req_ready, pipe_valid_o, rsp_valid, busy);
    end
    checks++;
    if (rsp_id !== '0 || rsp_pf !== '0 || rsp_qf !== '0 || rsp_angle !== '0 || pipe_p !== '0 || pipe_a !== '0) begin
      errors++;
      $display("FAIL reset_data: got id=%0d pf=%h qf=%h ang=%h pp=%h pa=%h, required all 0", rsp_id, rsp_pf, rsp_qf, rsp_angle, pipe_p, pipe_a);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    exp_p = drv_p[0];
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL reset_first_grant: got %b, required 0001", req_ready);
    end
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (pipe_valid_o !== 1'b1 || pipe_p !== exp_p || pipe_a !== 32'd0) begin
      errors++;
      $display("FAIL reset_issue: got pv=%b pp=%h pa=%h, required pv=1 pp=%h pa=0", pipe_valid_o, pipe_p, pipe_a, exp_p);
    end
    repeat (20) next_cycle();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL reset_drain: got busy=%b pending=%0d, required 0/0", busy, sb.size());
    end
  endtask

  task automatic test_single_job();
    do_reset();
    for (int c = 0; c <= 30; c++) begin
      set_ops(c);
      drv_p[2]  = 32'h100;
      drv_q[2]  = 32'h200;
      req_valid = (c == 10) ? 4'b0100 : 4'b0000;
      @(negedge clk);
      if (c == 10) begin
        checks++;
        if (req_ready !== 4'b0100) begin
          errors++;
          $display("FAIL single_ready: got %b, required 0100", req_ready);
        end
      end
      if (c == 10 || c == 12) begin
        checks++;
        if (pipe_valid_o !== 1'b0) begin
          errors++;
          $display("FAIL single_pv_low: cycle %0d got %b, required 0", c, pipe_valid_o);
        end
      end
      if (c == 11) begin
        checks++;
        if (pipe_valid_o !== 1'b1 || pipe_p !== 32'h100 || pipe_q !== 32'h200 || pipe_a !== 32'd2) begin
          errors++;
          $display("FAIL single_issue: got pv=%b p=%h q=%h a=%h, required 1/100/200/2", pipe_valid_o, pipe_p, pipe_q, pipe_a);
        end
      end
      if (c == 25) begin
        checks++;
        if (rsp_valid !== 1'b0) begin
          errors++;
          $display("FAIL single_early: got rsp_valid=%b at 25, required 0", rsp_valid);
        end
      end
      if (c == 26) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_pf !== 32'h100 || rsp_qf !== 32'h200 || rsp_angle !== 16'd2) begin
          errors++;
          $display("FAIL single_rsp: got v=%b id=%0d pf=%h qf=%h ang=%h, required 1/2/100/200/2",
                   rsp_valid, rsp_id, rsp_pf, rsp_qf, rsp_angle);
        end
      end
      if (c == 27) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL single_busy: got %b at 27, required 0", busy);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] exp_ready;
    do_reset();
    for (int c = 0; c <= 30; c++) begin
      set_ops(c);
      req_valid = (c >= 5 && c <= 8) ? 4'b1111 : 4'b0000;
      exp_ready = (c >= 5 && c <= 8) ? NREQ'(1 << (c - 5)) : '0;
      @(negedge clk);
      checks++;
      if (req_ready !== exp_ready) begin
        errors++;
        $display("FAIL rr_ready: cycle %0d got %b, required %b", c, req_ready, exp_ready);
      end
      if (c >= 21 && c <= 24) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== ID_W'(c - 21)) begin
          errors++;
          $display("FAIL rr_rsp_id: cycle %0d got v=%b id=%0d, required 1/%0d", c, rsp_valid, rsp_id, c - 21);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_credit_limit();
    logic [NREQ-1:0] exp_ready;
    do_reset();
    for (int c = 0; c <= 56; c++) begin
      set_ops(c);
      req_valid = (c <= 36) ? 4'b0001 : 4'b0000;
      exp_ready = (c <= 3 || (c >= 17 && c <= 20) || (c >= 34 && c <= 36)) ? 4'b0001 : 4'b0000;
      @(negedge clk);
      checks++;
      if (req_ready !== exp_ready) begin
        errors++;
        $display("FAIL credit_ready: cycle %0d got %b, required %b", c, req_ready, exp_ready);
      end
      next_cycle();
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL credit_drain: got busy=%b pending=%0d, required 0/0", busy, sb.size());
    end
  endtask

  task automatic test_sched_en_drain();
    logic [NREQ-1:0] exp_ready;
    do_reset();
    for (int c = 0; c <= 22; c++) begin
      set_ops(c);
      req_valid = 4'b1111;
      sched_en  = (c < 3);
      exp_ready = (c < 3) ? NREQ'(1 << c) : '0;
      @(negedge clk);
      checks++;
      if (req_ready !== exp_ready) begin
        errors++;
        $display("FAIL sched_ready: cycle %0d got %b, required %b", c, req_ready, exp_ready);
      end
      if (c == 18 || c == 19) begin
        checks++;
        if (busy !== (c == 18)) begin
          errors++;
          $display("FAIL sched_busy: cycle %0d got %b, required %b", c, busy, (c == 18));
        end
      end
      next_cycle();
    end
    sched_en = 1'b1;
  endtask

  task automatic test_mid_reset();
    logic [NREQ-1:0] exp_ready;
    do_reset();
    for (int c = 0; c <= 30; c++) begin
      set_ops(c);
      req_valid = (c <= 4 || c == 8 || c == 9) ? 4'b1111 : 4'b0000;
      if (c == 8) rst = 1'b1;
      if (c == 9) rst = 1'b0;
      exp_ready = (c <= 4) ? NREQ'(1 << (c % NREQ)) : ((c == 9) ? 4'b0001 : 4'b0000);
      @(negedge clk);
      checks++;
      if (req_ready !== exp_ready) begin
        errors++;
        $display("FAIL midrst_ready: cycle %0d got %b, required %b", c, req_ready, exp_ready);
      end
      if (c == 8) begin
        checks++;
        if (busy !== 1'b0 || pipe_valid_o !== 1'b0 || rsp_valid !== 1'b0) begin
          errors++;
          $display("FAIL midrst_outputs: got busy=%b pv=%b rv=%b, required 0", busy, pipe_valid_o, rsp_valid);
        end
      end
      if (c >= 9 && c <= 24) begin
        checks++;
        if (rsp_valid !== 1'b0) begin
          errors++;
          $display("FAIL midrst_stale: cycle %0d got rsp_valid=%b, required 0", c, rsp_valid);
        end
      end
      if (c == 25) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin
          errors++;
          $display("FAIL midrst_resume: got v=%b id=%0d, required 1/0", rsp_valid, rsp_id);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c <= 30; c++) begin
      set_ops(c);
      req_valid = (c < 12) ? 4'b1111 : 4'b0000;
      @(negedge clk);
      if (c < 12) begin
        checks++;
        if (req_ready !== NREQ'(1 << (c % NREQ))) begin
          errors++;
          $display("FAIL b2b_ready: cycle %0d got %b, required %b", c, req_ready, NREQ'(1 << (c % NREQ)));
        end
      end
      if (c >= 1 && c <= 12) begin
        checks++;
        if (pipe_valid_o !== 1'b1) begin
          errors++;
          $display("FAIL b2b_issue: cycle %0d got pv=%b, required 1", c, pipe_valid_o);
        end
      end
      next_cycle();
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain: got busy=%b pending=%0d, required 0/0", busy, sb.size());
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c <= 100; c++) begin
      set_ops(c);
      req_valid = (c < 80) ? NREQ'($urandom_range(0, 15)) : '0;
      sched_en  = ($urandom_range(0, 7) != 0);
      @(negedge clk);
      checks++;
      if (!$onehot0(req_ready) || (req_ready & ~(req_valid & {NREQ{sched_en}})) != '0) begin
        errors++;
        $display("FAIL rand_grant: cycle %0d got ready=%b with valid=%b en=%b, required one-hot subset",
                 c, req_ready, req_valid, sched_en);
      end
      next_cycle();
    end
    sched_en = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL rand_drain: got busy=%b pending=%0d, required 0/0", busy, sb.size());
    end
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      drv_a[i] = '0;
      drv_b[i] = '0;
      drv_p[i] = '0;
      drv_q[i] = '0;
    end
    test_reset();
    test_single_job();
    test_round_robin();
    test_credit_limit();
    test_sched_en_drain();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
